// File: rtl/register_file.sv
// register_file
//   Architectural register file plus rename table for the out-of-order core.
//   The reorder buffer commits results in order through the commit_* port.
//   Dispatch records the producer tag of each destination register through
//   the rename_* port. Decoder source operands are resolved combinationally:
//   from the register file, from the ROB (queried by producer tag), or from a
//   commit that arrives in the same cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               misprediction flush: clears every busy bit
//   rename_en/regid/tag new producer tag for a destination register
//   rs1_id, rs2_id      decoder source registers
//   query_vregid1/2     producer tag sent to the ROB for rs1/rs2
//   query_dependency1/2 ROB: 1 = producer value not yet available
//   query_val1/2        ROB: producer value
//   commit_en/regid/tag/val  in-order writeback from the ROB
//   rs1_*/rs2_*         resolved operands: ready, producer tag, value
module register_file #(
  parameter int XLEN    = 32,
  parameter int REG_CNT = 32,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             rename_en,
  input  logic [4:0]       rename_regid,
  input  logic [TAG_W-1:0] rename_tag,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  output logic [TAG_W-1:0] query_vregid1,
  output logic [TAG_W-1:0] query_vregid2,
  input  logic             query_dependency1,
  input  logic             query_dependency2,
  input  logic [XLEN-1:0]  query_val1,
  input  logic [XLEN-1:0]  query_val2,
  input  logic             commit_en,
  input  logic [4:0]       commit_regid,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_val,
  output logic             rs1_ready,
  output logic             rs2_ready,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag,
  output logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  rs2_val
);

  logic [XLEN-1:0]  regs_q [REG_CNT];
  logic [XLEN-1:0]  regs_d [REG_CNT];
  logic [TAG_W-1:0] tag_q  [REG_CNT];
  logic [TAG_W-1:0] tag_d  [REG_CNT];
  logic [REG_CNT-1:0] busy_q;
  logic [REG_CNT-1:0] busy_d;

  // Next state. Commit is applied first so that a same-cycle rename of the
  // same register overrides the busy clear and installs the newer tag.
  always_comb begin
    regs_d = regs_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_en && commit_regid != 5'd0) begin
      regs_d[commit_regid] = commit_val;
      // Only the most recent producer releases the register.
      if (tag_q[commit_regid] == commit_tag) begin
        busy_d[commit_regid] = 1'b0;
      end
    end
    if (flush) begin
      // Tags are left as they are; with busy clear they are never consulted.
      busy_d = '0;
    end else if (rename_en && rename_regid != 5'd0) begin
      busy_d[rename_regid] = 1'b1;
      tag_d[rename_regid]  = rename_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  // Operand resolution always uses the pre-edge state, so a source equal to
  // this cycle's rename destination still sees the old mapping.
  always_comb begin
    query_vregid1 = tag_q[rs1_id];
    rs1_tag       = tag_q[rs1_id];
    rs1_ready     = 1'b1;
    rs1_val       = regs_q[rs1_id];
    if (rs1_id == 5'd0) begin
      rs1_val = '0;
    end else if (busy_q[rs1_id]) begin
      if (commit_en && commit_regid == rs1_id && commit_tag == tag_q[rs1_id]) begin
        rs1_val = commit_val;
      end else begin
        rs1_ready = !query_dependency1;
        rs1_val   = query_val1;
      end
    end
  end

  always_comb begin
    query_vregid2 = tag_q[rs2_id];
    rs2_tag       = tag_q[rs2_id];
    rs2_ready     = 1'b1;
    rs2_val       = regs_q[rs2_id];
    if (rs2_id == 5'd0) begin
      rs2_val = '0;
    end else if (busy_q[rs2_id]) begin
      if (commit_en && commit_regid == rs2_id && commit_tag == tag_q[rs2_id]) begin
        rs2_val = commit_val;
      end else begin
        rs2_ready = !query_dependency2;
        rs2_val   = query_val2;
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst, flush, rename_en, commit_en;
  logic [4:0]  rename_regid, rs1_id, rs2_id, commit_regid;
  logic [4:0]  rename_tag, commit_tag;
  logic [4:0]  query_vregid1, query_vregid2, rs1_tag, rs2_tag;
  logic        query_dependency1, query_dependency2;
  logic [31:0] query_val1, query_val2, commit_val;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_val, rs2_val;

  always #5 clk = ~clk;

  register_file dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rename_en(rename_en), .rename_regid(rename_regid), .rename_tag(rename_tag),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .query_vregid1(query_vregid1), .query_vregid2(query_vregid2),
    .query_dependency1(query_dependency1), .query_dependency2(query_dependency2),
    .query_val1(query_val1), .query_val2(query_val2),
    .commit_en(commit_en), .commit_regid(commit_regid),
    .commit_tag(commit_tag), .commit_val(commit_val),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .rs1_val(rs1_val), .rs2_val(rs2_val)
  );

  // Reference model: architectural view of the register file.
  int unsigned m_val  [32];
  int unsigned m_tag  [32];
  bit          m_busy [32];
  bit          model_valid = 0;

  typedef struct {
    bit          ready;
    int unsigned val;
    int unsigned tag;
    bit          busy;
  } rd_t;

  typedef struct {
    rd_t p1;
    rd_t p2;
    int  cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  function automatic rd_t predict(int id, bit dep, int unsigned qv);
    rd_t r;
    r.tag  = m_tag[id];
    r.busy = (id != 0) && m_busy[id];
    if (id == 0) begin
      r.ready = 1; r.val = 0;
    end else if (!m_busy[id]) begin
      r.ready = 1; r.val = m_val[id];
    end else if (commit_en && int'(commit_regid) == id && int'(commit_tag) == m_tag[id]) begin
      r.ready = 1; r.val = commit_val;
    end else begin
      r.ready = !dep; r.val = qv;
    end
    return r;
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0; m_tag[i] = 0; m_busy[i] = 0;
      end
      model_valid = 1;
    end else begin
      if (commit_en && commit_regid != 0) begin
        m_val[commit_regid] = commit_val;
        if (m_tag[commit_regid] == int'(commit_tag)) m_busy[commit_regid] = 0;
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else if (rename_en && rename_regid != 0) begin
        m_busy[rename_regid] = 1;
        m_tag[rename_regid]  = rename_tag;
      end
    end
  endtask

  // Called with inputs already driven (#1 after a posedge): queue the
  // expected read result, then advance the model across the next edge.
  task automatic step();
    exp_t e;
    if (model_valid) begin
      e.p1  = predict(rs1_id, query_dependency1, query_val1);
      e.p2  = predict(rs2_id, query_dependency2, query_val2);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; rename_en = 0; commit_en = 0;
    rename_regid = 0; rename_tag = 0; commit_regid = 0; commit_tag = 0; commit_val = 0;
    query_dependency1 = 0; query_dependency2 = 0; query_val1 = 0; query_val2 = 0;
  endtask

  task automatic chk(string name, int cy, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: actual=%h required=%h", name, cy, act, req);
    end
  endtask

  // Monitor: the read port presents a result every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rs1_ready", e.cyc, 32'(rs1_ready), 32'(e.p1.ready));
      chk("rs2_ready", e.cyc, 32'(rs2_ready), 32'(e.p2.ready));
      chk("query_vregid1", e.cyc, 32'(query_vregid1), e.p1.tag);
      chk("query_vregid2", e.cyc, 32'(query_vregid2), e.p2.tag);
      if (e.p1.ready) chk("rs1_val", e.cyc, rs1_val, e.p1.val);
      if (e.p2.ready) chk("rs2_val", e.cyc, rs2_val, e.p2.val);
      if (e.p1.busy)  chk("rs1_tag", e.cyc, 32'(rs1_tag), e.p1.tag);
      if (e.p2.busy)  chk("rs2_tag", e.cyc, 32'(rs2_tag), e.p2.tag);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rs1_id = 5; rs2_id = 0;
    rst = 1;
    @(posedge clk); #1;
    step();
    rst = 0;
    // Reset values
    rs1_id = 5; rs2_id = 0; step();
    // Rename x5 -> tag 3, then read through the ROB query
    rename_en = 1; rename_regid = 5; rename_tag = 3; rs1_id = 5; step();
    idle(); rs1_id = 5; query_dependency1 = 1; step();
    query_dependency1 = 0; query_val1 = 32'h1234; step();
    // Same-cycle commit bypass, then committed value from the file
    idle(); rs1_id = 5; rs2_id = 5; query_dependency1 = 1; query_dependency2 = 1;
    commit_en = 1; commit_regid = 5; commit_tag = 3; commit_val = 32'hAB; step();
    idle(); rs1_id = 5; query_dependency1 = 1; step();
    // Rename to a newer producer while the older one commits
    rename_en = 1; rename_regid = 5; rename_tag = 3; step();
    idle(); rename_en = 1; rename_regid = 5; rename_tag = 7;
    commit_en = 1; commit_regid = 5; commit_tag = 3; commit_val = 32'h11; step();
    idle(); rs1_id = 5; query_dependency1 = 1; step();
    commit_en = 1; commit_regid = 5; commit_tag = 7; commit_val = 32'h22; step();
    idle(); rs1_id = 5; step();
    // Flush with same-cycle commit and rename
    rename_en = 1; rename_regid = 6; rename_tag = 9; step();
    idle(); flush = 1; commit_en = 1; commit_regid = 1; commit_tag = 8; commit_val = 32'h40;
    rename_en = 1; rename_regid = 7; rename_tag = 10; step();
    idle(); rs1_id = 1; rs2_id = 6; query_dependency2 = 1; step();
    rs1_id = 7; rs2_id = 6; query_dependency1 = 1; step();
    // x0 is never written and never busy
    idle(); commit_en = 1; commit_regid = 0; commit_val = 32'hFF;
    rename_en = 1; rename_regid = 0; rename_tag = 4; step();
    idle(); rs1_id = 0; rs2_id = 0; query_dependency1 = 1; step();

    // Randomized traffic over a small register window to force collisions
    for (int i = 0; i < 3000; i++) begin
      idle();
      rst          = ($urandom_range(0, 299) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      rename_en    = $urandom_range(0, 1);
      rename_regid = 5'($urandom_range(0, 7));
      rename_tag   = 5'($urandom);
      commit_en    = $urandom_range(0, 1);
      commit_regid = 5'($urandom_range(0, 7));
      commit_tag   = ($urandom_range(0, 2) != 0) ? 5'(m_tag[commit_regid]) : 5'($urandom);
      commit_val   = $urandom;
      rs1_id       = ($urandom_range(0, 3) == 0) ? commit_regid : 5'($urandom_range(0, 7));
      rs2_id       = ($urandom_range(0, 3) == 0) ? rename_regid : 5'($urandom_range(0, 7));
      query_dependency1 = $urandom_range(0, 1);
      query_dependency2 = $urandom_range(0, 1);
      query_val1   = $urandom;
      query_val2   = $urandom;
      step();
    end

    idle();
    @(negedge clk); #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
